// File: rtl/control_fsm_if.sv
// Control/status bundle between control_fsm (master) and the 16-bit datapath (slave).
interface control_fsm_if;
  logic [15:0] instr;
  logic        zero_flag;
  logic        mem_ready;
  logic        pc_clr;
  logic        pc_inc;
  logic        pc_load;
  logic        ir_load;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic [2:0]  alu_op;
  logic        mem_rd;
  logic        mem_wr;
  logic        addr_sel;
  logic        halted;
  logic        illegal_op;
  logic        mem_timeout;
  logic [2:0]  state;

  modport master (
    input  instr, zero_flag, mem_ready,
    output pc_clr, pc_inc, pc_load, ir_load, rf_we, rf_wsel, alu_op,
           mem_rd, mem_wr, addr_sel, halted, illegal_op, mem_timeout, state
  );

  modport slave (
    output instr, zero_flag, mem_ready,
    input  pc_clr, pc_inc, pc_load, ir_load, rf_we, rf_wsel, alu_op,
           mem_rd, mem_wr, addr_sel, halted, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer for the 16-bit datapath (BOOT/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define CTRL_ILLEGAL_TRAP_EN to halt on opcodes A-E; otherwise they execute as NOP.
module control_fsm #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WAIT_W     = 4
) (
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_LIMIT[WAIT_W-1:0];

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              timeout_q;
  logic              timeout_hit;
  logic              illegal_q;
  logic [3:0]        opcode;
  logic              waiting;
  logic              wait_expired;

  assign opcode       = bus.instr[15:12];
  assign waiting      = ((state_q == FETCH) || (state_q == MEM)) && !bus.mem_ready;
  assign wait_expired = waiting && (wait_q == LIMIT);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_hit;
`endif

  // State register plus wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (illegal_hit) begin
      illegal_q <= 1'b1;
    end
  end
`else
  assign illegal_q = 1'b0;
`endif

  // Next-state logic; the wait counter restarts on every state change and saturates at LIMIT
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_hit = 1'b0;
`endif
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (bus.mem_ready) begin
          state_d = DECODE;
        end else if (wait_expired) begin
          state_d     = HALT;
          timeout_hit = 1'b1;
        end
      end
      DECODE: begin
        case (opcode)
          OP_NOP:                      state_d = FETCH;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_LD, OP_ST, OP_JMP, OP_BEQ: state_d = EXEC;
          OP_LDI:                      state_d = WB;
          OP_HALT:                     state_d = HALT;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d     = HALT;
            illegal_hit = 1'b1;
`else
            state_d     = FETCH;
`endif
          end
        endcase
      end
      EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = WB;
          OP_LD, OP_ST:                  state_d = MEM;
          default:                       state_d = FETCH;
        endcase
      end
      MEM: begin
        if (bus.mem_ready) begin
          state_d = (opcode == OP_LD) ? WB : FETCH;
        end else if (wait_expired) begin
          state_d     = HALT;
          timeout_hit = 1'b1;
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && (wait_q != LIMIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Moore outputs; only pc_inc/ir_load in FETCH and pc_load for BEQ look at live inputs
  always_comb begin
    bus.pc_clr   = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.ir_load  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_wsel  = 2'd0;
    bus.alu_op   = 3'd0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.halted   = 1'b0;
    unique case (state_q)
      BOOT: bus.pc_clr = 1'b1;
      FETCH: begin
        bus.mem_rd  = 1'b1;
        bus.pc_inc  = bus.mem_ready;
        bus.ir_load = bus.mem_ready;
      end
      DECODE: ;
      EXEC: begin
        case (opcode)
          OP_SUB:  bus.alu_op  = 3'd1;
          OP_AND:  bus.alu_op  = 3'd2;
          OP_OR:   bus.alu_op  = 3'd3;
          OP_JMP:  bus.pc_load = 1'b1;
          OP_BEQ:  bus.pc_load = bus.zero_flag;
          default: bus.alu_op  = 3'd0;
        endcase
      end
      MEM: begin
        bus.addr_sel = 1'b1;
        if (opcode == OP_ST) begin
          bus.mem_wr = 1'b1;
        end else begin
          bus.mem_rd = 1'b1;
        end
      end
      WB: begin
        bus.rf_we = 1'b1;
        if (opcode == OP_LDI) begin
          bus.rf_wsel = 2'd1;
        end else if (opcode == OP_LD) begin
          bus.rf_wsel = 2'd2;
        end
      end
      HALT:    bus.halted = 1'b1;
      default: bus.pc_clr = 1'b1;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.mem_timeout = timeout_q;
  assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle stimulus with expected output vectors.
module tb_control_fsm;

  logic clk;
  logic reset;

  control_fsm_if bus ();

  control_fsm #(.WAIT_LIMIT(15), .WAIT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [10:0] F_CLR = 11'h001, F_INC = 11'h002, F_LOAD = 11'h004, F_IR  = 11'h008,
                          F_WE  = 11'h010, F_RD  = 11'h020, F_WR   = 11'h040, F_AS  = 11'h080,
                          F_HLT = 11'h100, F_ILL = 11'h200, F_TMO  = 11'h400;

  // {state, alu_op, rf_wsel, flags}
  logic [18:0] obs;
  assign obs = {bus.state, bus.alu_op, bus.rf_wsel,
                bus.mem_timeout, bus.illegal_op, bus.halted, bus.addr_sel, bus.mem_wr,
                bus.mem_rd, bus.rf_we, bus.ir_load, bus.pc_load, bus.pc_inc, bus.pc_clr};

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        zf;
    logic        mr;
    logic [18:0] exp;
  } stim_t;

  stim_t       stim_q[$];
  logic [18:0] sb_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  function automatic logic [18:0] ev(input logic [2:0] st, input logic [10:0] fl,
                                     input logic [1:0] ws = 2'd0, input logic [2:0] ao = 3'd0);
    return {st, ao, ws, fl};
  endfunction

  task automatic add(input logic rst, input logic [15:0] ins, input logic zf, input logic mr,
                     input logic [18:0] e);
    stim_t s;
    s.rst = rst; s.instr = ins; s.zf = zf; s.mr = mr; s.exp = e;
    stim_q.push_back(s);
  endtask

  task automatic push_reset();
    for (int unsigned i = 0; i < 3; i++) add(1'b1, 16'h0000, 1'b0, 1'b0, ev(S_BOOT, F_CLR));
    add(1'b0, 16'h0000, 1'b0, 1'b0, ev(S_BOOT, F_CLR));
  endtask

  // Drive one cycle of stimulus at the falling edge; the expected vector rides the scoreboard.
  task automatic step(output logic [18:0] e);
    stim_t s;
    s = stim_q.pop_front();
    @(negedge clk);
    reset         = s.rst;
    bus.instr     = s.instr;
    bus.zero_flag = s.zf;
    bus.mem_ready = s.mr;
    sb_q.push_back(s.exp);
    #2;
    e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    logic [18:0] e;
    int unsigned n = 0;
    push_reset();
    add(0, 16'h0000, 0, 0, ev(S_FETCH, F_RD));
    add(0, 16'h0000, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h0000, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h0000, 0, 0, ev(S_FETCH, F_RD));
    while (stim_q.size() > 0) begin
      step(e); vectors++; n++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got state=%0d outs=%h, expected state=%0d outs=%h",
                 n, obs[18:16], obs[15:0], e[18:16], e[15:0]);
      end
    end
  endtask

  task automatic test_alu();
    logic [18:0] e;
    int unsigned n = 0;
    logic [15:0] ins;
    logic [2:0]  aop [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    push_reset();
    for (int unsigned k = 0; k < 4; k++) begin
      ins = 16'h0000;
      ins[15:12] = 4'(k + 1);
      ins[11:0]  = 12'h5A3;
      add(0, ins, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
      add(0, ins, 0, 0, ev(S_DECODE, '0));
      add(0, ins, 1, 0, ev(S_EXEC, '0, 2'd0, aop[k]));
      add(0, ins, 0, 0, ev(S_WB, F_WE, 2'd0));
    end
    add(0, 16'h0000, 0, 0, ev(S_FETCH, F_RD));
    while (stim_q.size() > 0) begin
      step(e); vectors++; n++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL alu[%0d]: got state=%0d outs=%h, expected state=%0d outs=%h",
                 n, obs[18:16], obs[15:0], e[18:16], e[15:0]);
      end
    end
  endtask

  task automatic test_ld_wait();
    logic [18:0] e;
    int unsigned n = 0;
    push_reset();
    add(0, 16'h6123, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h6123, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h6123, 0, 0, ev(S_EXEC, '0, 2'd0, 3'd0));
    for (int unsigned i = 0; i < 3; i++) add(0, 16'h6123, 0, 0, ev(S_MEM, F_RD | F_AS));
    add(0, 16'h6123, 0, 1, ev(S_MEM, F_RD | F_AS));
    add(0, 16'h6123, 0, 0, ev(S_WB, F_WE, 2'd2));
    add(0, 16'h7456, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h7456, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h7456, 0, 0, ev(S_EXEC, '0, 2'd0, 3'd0));
    add(0, 16'h7456, 0, 1, ev(S_MEM, F_WR | F_AS));
    add(0, 16'h7456, 0, 0, ev(S_FETCH, F_RD));
    while (stim_q.size() > 0) begin
      step(e); vectors++; n++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL ld_st[%0d]: got state=%0d outs=%h, expected state=%0d outs=%h",
                 n, obs[18:16], obs[15:0], e[18:16], e[15:0]);
      end
    end
  endtask

  task automatic test_branch();
    logic [18:0] e;
    int unsigned n = 0;
    push_reset();
    add(0, 16'h8040, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h8040, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h8040, 0, 0, ev(S_EXEC, F_LOAD));
    add(0, 16'h9010, 1, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h9010, 1, 0, ev(S_DECODE, '0));
    add(0, 16'h9010, 0, 0, ev(S_EXEC, '0));
    add(0, 16'h9020, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h9020, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h9020, 1, 0, ev(S_EXEC, F_LOAD));
    add(0, 16'h0000, 1, 0, ev(S_FETCH, F_RD));
    while (stim_q.size() > 0) begin
      step(e); vectors++; n++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL branch[%0d]: got state=%0d outs=%h, expected state=%0d outs=%h",
                 n, obs[18:16], obs[15:0], e[18:16], e[15:0]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [18:0] e;
    int unsigned n = 0;
    push_reset();
    // 15 low cycles in FETCH are tolerated
    for (int unsigned i = 0; i < 15; i++) add(0, 16'h0000, 0, 0, ev(S_FETCH, F_RD));
    add(0, 16'h0000, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h0000, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h6001, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h6001, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h6001, 0, 0, ev(S_EXEC, '0));
    for (int unsigned i = 0; i < 15; i++) add(0, 16'h6001, 0, 0, ev(S_MEM, F_RD | F_AS));
    add(0, 16'h6001, 0, 1, ev(S_MEM, F_RD | F_AS));
    add(0, 16'h6001, 0, 0, ev(S_WB, F_WE, 2'd2));
    // 16th low cycle in FETCH halts
    for (int unsigned i = 0; i < 16; i++) add(0, 16'h0000, 0, 0, ev(S_FETCH, F_RD));
    for (int unsigned i = 0; i < 3; i++) add(0, 16'h0000, 0, i[0], ev(S_HALT, F_HLT | F_TMO));
    push_reset();
    add(0, 16'h7002, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h7002, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h7002, 0, 0, ev(S_EXEC, '0));
    for (int unsigned i = 0; i < 16; i++) add(0, 16'h7002, 0, 0, ev(S_MEM, F_WR | F_AS));
    add(0, 16'h7002, 0, 1, ev(S_HALT, F_HLT | F_TMO));
    push_reset();
    while (stim_q.size() > 0) begin
      step(e); vectors++; n++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got state=%0d outs=%h, expected state=%0d outs=%h",
                 n, obs[18:16], obs[15:0], e[18:16], e[15:0]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] e;
    int unsigned n = 0;
    logic [15:0] ins;
    logic [3:0]  ops [3] = '{4'hA, 4'hB, 4'hE};
    for (int unsigned k = 0; k < 3; k++) begin
      ins = 16'h0000;
      ins[15:12] = ops[k];
      push_reset();
      add(0, ins, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
      add(0, ins, 0, 0, ev(S_DECODE, '0));
`ifdef CTRL_ILLEGAL_TRAP_EN
      add(0, ins, 0, 1, ev(S_HALT, F_HLT | F_ILL));
      add(0, ins, 0, 0, ev(S_HALT, F_HLT | F_ILL));
`else
      add(0, ins, 0, 0, ev(S_FETCH, F_RD));
      add(0, ins, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
`endif
    end
    push_reset();
    add(0, 16'hF000, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'hF000, 0, 0, ev(S_DECODE, '0));
    for (int unsigned i = 0; i < 3; i++) add(0, 16'h1000, 1, 1, ev(S_HALT, F_HLT));
    while (stim_q.size() > 0) begin
      step(e); vectors++; n++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL illegal_halt[%0d]: got state=%0d outs=%h, expected state=%0d outs=%h",
                 n, obs[18:16], obs[15:0], e[18:16], e[15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] e;
    int unsigned n = 0;
    push_reset();
    add(0, 16'h5111, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h5111, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h5111, 0, 0, ev(S_WB, F_WE, 2'd1));
    add(0, 16'h0000, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h0000, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h7333, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h7333, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h7333, 0, 0, ev(S_EXEC, '0));
    add(0, 16'h7333, 0, 0, ev(S_MEM, F_WR | F_AS));
    // reset mid-store: aborted immediately, no write on release
    add(1, 16'h7333, 0, 1, ev(S_BOOT, F_CLR));
    add(1, 16'h7333, 0, 1, ev(S_BOOT, F_CLR));
    add(0, 16'h7333, 0, 1, ev(S_BOOT, F_CLR));
    add(0, 16'h2444, 0, 1, ev(S_FETCH, F_RD | F_INC | F_IR));
    add(0, 16'h2444, 0, 0, ev(S_DECODE, '0));
    add(0, 16'h2444, 0, 0, ev(S_EXEC, '0, 2'd0, 3'd1));
    add(0, 16'h2444, 0, 0, ev(S_WB, F_WE, 2'd0));
    add(0, 16'h0000, 0, 0, ev(S_FETCH, F_RD));
    while (stim_q.size() > 0) begin
      step(e); vectors++; n++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got state=%0d outs=%h, expected state=%0d outs=%h",
                 n, obs[18:16], obs[15:0], e[18:16], e[15:0]);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.instr     = 16'h0000;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_ld_wait();
    test_branch();
    test_timeout();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
